axi_slv_model: RTL and testbench
================================

Name: axi_slv_model

Overview:
Parametrised, synthesizable AXI3-style slave responder for crossbar testbenches; next generation of the random-ready slave stub.
- Tracks AW, W and AR transactions in real FIFOs of configurable depth.
- Returns in-order B and R responses with deterministic, address-derived read data.
- Returns SLVERR for a configurable address window.
- Applies LFSR-driven ready back-pressure, selectable per mode.
- One instance sits on each crossbar slave port.

Parameters:
AXI_ADDR_W, 32, address width
AXI_ID_W, 4, ID width at slave side
AXI_DATA_W, 32, data width (power of 2, >=8)
OSTD_DEPTH, 4, outstanding depth of each of the AW, B and AR FIFOs (power of 2, >=2)
BP_MODE, 1, 0 = readies always asserted when FIFO space allows; 1 = readies additionally gated by LFSR bits
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)
ERR_BASE, 32'hF000_0000, SLVERR window base
ERR_MASK, 32'hF000_0000, address bits compared against ERR_BASE
RD_LAT, 3, extra cycles before first R beat (optional feature only)

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
awvalid/awready  in/out  1  AW handshake
awid, awaddr, awlen  in  AXI_ID_W, AXI_ADDR_W, 4  AW payload
wvalid/wready  in/out  1  W handshake
wlast  in  1  last write beat
bvalid/bready  out/in  1  B handshake
bid, bresp  out  AXI_ID_W, 2  B payload
arvalid/arready  in/out  1  AR handshake
arid, araddr, arlen  in  AXI_ID_W, AXI_ADDR_W, 4  AR payload
rvalid/rready  out/in  1  R handshake
rid, rdata, rresp, rlast  out  AXI_ID_W, AXI_DATA_W, 2, 1  R payload
proto_err  out  1  sticky: wlast disagreed with beat count

Behaviour:
- Reset: aresetn asynchronous active-low; clock aclk. All FIFOs empty, counters 0, LFSR = LFSR_SEED. All readies, valids, bid, bresp, rid, rdata, rresp, rlast and proto_err = 0 until the first aclk edge after deassertion.
- Reset mid-burst: all in-flight state is discarded; no partial response is emitted after reset.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advances every cycle. bp_aw = bit0, bp_w = bit5, bp_ar = bit10; each is forced to 1 when BP_MODE = 0.
- AW: awready = !aw_full & bp_aw. On handshake push {awid, awlen, err}, with err = ((awaddr & ERR_MASK) == (ERR_BASE & ERR_MASK)).
- W: wready = !aw_empty & !b_full & bp_w. Beat counter wbeat (4 bits) compared to the AW head len.
  - On a W handshake with wbeat == len: push {id, err ? 2'b10 : 2'b00} to B FIFO, pop AW, clear wbeat; otherwise wbeat++.
  - proto_err sets when wlast != (wbeat == len) on any W handshake. Sequencing always follows the count, never wlast.
  - W data before AW is held off (wready = 0).
- B: bvalid = !b_empty; bid/bresp are the FIFO head and stay stable while bvalid & !bready. Pop on handshake.
  - Earliest B: cycle after the last W handshake.
- AR: arready = !ar_full & bp_ar. Push {arid, araddr, arlen, err}.
- R: serves the AR head in order; no interleaving.
  - rvalid = !ar_empty; earliest first beat is the cycle after the AR handshake.
  - rdata = zero-extend/truncate(araddr_aligned + rbeat*(AXI_DATA_W/8)), where araddr_aligned clears the log2(AXI_DATA_W/8) LSBs.
  - rresp = err ? 2'b10 : 2'b00 on every beat.
  - rlast = rvalid & (rbeat == len). Payload is stable while rvalid & !rready.
  - On handshake: rbeat++; on the last beat pop AR and clear rbeat.
- FIFOs: pointers log2(OSTD_DEPTH)+1 bits with wrap bit. Full means pointers equal except the MSB.
  - Push is impossible when full because ready is low.
  - Simultaneous push and pop is legal at any level, including with count = 1.
- Channels are independent; reads and writes may complete concurrently.

Optional Feature:
AXI_SLV_MODEL_RDLAT_EN
- Defined: a per-burst counter loads RD_LAT when a new AR head becomes valid. rvalid is held 0 until the counter reaches 0, so the first beat comes RD_LAT cycles later than without the macro. Subsequent beats are unaffected.
- Undefined: no counter; timing as in Behaviour.

Decomposition:
- axi_slv_model_pkg: RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10; LFSR taps localparam; beat-counter width.
- Sub-module axi_slv_model_fifo (WIDTH, DEPTH; push, pop, full, empty, head), instantiated three times (AW, B, AR).

Test Plan:
- BP_MODE = 0, AW id 3, addr 0x100, len 3, then 4 W beats with wlast on beat 3 -> one B with bid = 3, bresp = 00, bvalid the cycle after the last beat; proto_err = 0.
- AR id 5, addr 0x204, len 2 -> rdata 0x204, 0x208, 0x20C; rlast only on the third beat; rid = 5, rresp = 00.
- AR addr 0xF000_0010 len 0 and AW addr 0xF000_0000 len 0 -> rresp = 10, rlast = 1 on the single beat; bresp = 10.
- Issue 6 ARs (OSTD_DEPTH = 4) with rready = 0 -> arready low after the 4th; after releasing rready, all 6 complete in order with correct rid values.
- wlast asserted on beat 1 of a len = 3 burst -> proto_err = 1 and sticky; B still issued after beat 3.
- BP_MODE = 1, 200 random bursts with random bready/rready -> every response matches a scoreboard; payloads stable under stall; reset mid-burst returns all outputs to 0.

Source files
------------

// File: rtl/axi_slv_model_pkg.sv
// Shared constants for the AXI3 slave responder: response codes, LFSR
// polynomial and burst beat-counter width.
package axi_slv_model_pkg;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  // Right-shifting Fibonacci taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS   = 16'h002D;
  localparam int          BEAT_W      = 4;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction
endpackage

// File: rtl/axi_slv_model_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head is the unregistered
// oldest entry, push and pop may coincide at any fill level.
module axi_slv_model_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/axi_slv_model.sv
// AXI3 slave responder: FIFO-tracked AW/W/B and AR/R with LFSR back-pressure.
// Define AXI_SLV_MODEL_RDLAT_EN to delay the first R beat of each burst by RD_LAT.
module axi_slv_model
  import axi_slv_model_pkg::*;
#(
  parameter int                    AXI_ADDR_W = 32,
  parameter int                    AXI_ID_W   = 4,
  parameter int                    AXI_DATA_W = 32,
  parameter int                    OSTD_DEPTH = 4,
  parameter int                    BP_MODE    = 1,
  parameter logic [15:0]           LFSR_SEED  = 16'hACE1,
  parameter logic [AXI_ADDR_W-1:0] ERR_BASE   = AXI_ADDR_W'(32'hF000_0000),
  parameter logic [AXI_ADDR_W-1:0] ERR_MASK   = AXI_ADDR_W'(32'hF000_0000),
  parameter int                    RD_LAT     = 3
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [AXI_ID_W-1:0]   awid,
  input  logic [AXI_ADDR_W-1:0] awaddr,
  input  logic [3:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [AXI_ID_W-1:0]   bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [AXI_ID_W-1:0]   arid,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic [3:0]            arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [AXI_ID_W-1:0]   rid,
  output logic [AXI_DATA_W-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  proto_err
);
  localparam int BYTES   = AXI_DATA_W / 8;
  localparam int ALIGN_W = $clog2(BYTES);
  localparam int AWF_W   = AXI_ID_W + BEAT_W + 1;
  localparam int BF_W    = AXI_ID_W + 2;
  localparam int ARF_W   = AXI_ID_W + AXI_ADDR_W + BEAT_W + 1;

  // Readies stay low until the first edge after reset release
  logic        en;
  logic [15:0] lfsr;
  logic        bp_aw, bp_w, bp_ar;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en   <= 1'b0;
      lfsr <= LFSR_SEED;
    end else begin
      en   <= 1'b1;
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign bp_aw = (BP_MODE == 0) || lfsr[0];
  assign bp_w  = (BP_MODE == 0) || lfsr[5];
  assign bp_ar = (BP_MODE == 0) || lfsr[10];

  // ---- write path ----
  logic                aw_full, aw_empty, aw_push, aw_pop, aw_err;
  logic [AWF_W-1:0]    aw_head;
  logic [AXI_ID_W-1:0] aw_id_h;
  logic [BEAT_W-1:0]   aw_len_h, wbeat;
  logic                aw_err_h, w_hs, w_end;
  logic                b_full, b_empty;
  logic [BF_W-1:0]     b_head;

  assign aw_err  = (awaddr & ERR_MASK) == (ERR_BASE & ERR_MASK);
  assign awready = en && !aw_full && bp_aw;
  assign aw_push = awvalid && awready;
  assign {aw_id_h, aw_len_h, aw_err_h} = aw_head;

  assign wready = en && !aw_empty && !b_full && bp_w;
  assign w_hs   = wvalid && wready;
  assign w_end  = (wbeat == aw_len_h);
  assign aw_pop = w_hs && w_end;

  axi_slv_model_fifo #(.WIDTH(AWF_W), .DEPTH(OSTD_DEPTH)) u_aw_fifo (
    .aclk, .aresetn, .push(aw_push), .din({awid, awlen, aw_err}), .pop(aw_pop),
    .full(aw_full), .empty(aw_empty), .head(aw_head)
  );

  // Sequencing follows the beat count; wlast only feeds the sticky error
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wbeat     <= '0;
      proto_err <= 1'b0;
    end else if (w_hs) begin
      wbeat <= w_end ? '0 : wbeat + BEAT_W'(1);
      if (wlast != w_end) proto_err <= 1'b1;
    end
  end

  axi_slv_model_fifo #(.WIDTH(BF_W), .DEPTH(OSTD_DEPTH)) u_b_fifo (
    .aclk, .aresetn, .push(aw_pop), .din({aw_id_h, aw_err_h ? RESP_SLVERR : RESP_OKAY}),
    .pop(bvalid && bready), .full(b_full), .empty(b_empty), .head(b_head)
  );

  assign bvalid        = !b_empty;
  assign {bid, bresp}  = bvalid ? b_head : '0;

  // ---- read path ----
  logic                  ar_full, ar_empty, ar_pop, ar_err, lat_ok, r_end;
  logic [ARF_W-1:0]      ar_head;
  logic [AXI_ID_W-1:0]   ar_id_h;
  logic [AXI_ADDR_W-1:0] ar_addr_h, rd_addr;
  logic [BEAT_W-1:0]     ar_len_h, rbeat;
  logic                  ar_err_h;

  assign ar_err  = (araddr & ERR_MASK) == (ERR_BASE & ERR_MASK);
  assign arready = en && !ar_full && bp_ar;
  assign {ar_id_h, ar_addr_h, ar_len_h, ar_err_h} = ar_head;

  axi_slv_model_fifo #(.WIDTH(ARF_W), .DEPTH(OSTD_DEPTH)) u_ar_fifo (
    .aclk, .aresetn, .push(arvalid && arready), .din({arid, araddr, arlen, ar_err}),
    .pop(ar_pop), .full(ar_full), .empty(ar_empty), .head(ar_head)
  );

`ifdef AXI_SLV_MODEL_RDLAT_EN
  // Reloaded while no head is waiting, so each new head starts a full countdown
  logic [7:0] lat_cnt;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                lat_cnt <= 8'(RD_LAT);
    else if (ar_empty || ar_pop) lat_cnt <= 8'(RD_LAT);
    else if (lat_cnt != '0)      lat_cnt <= lat_cnt - 8'd1;
  end
  assign lat_ok = (lat_cnt == '0);
`else
  logic [31:0] unused_rd_lat;
  assign unused_rd_lat = RD_LAT;
  assign lat_ok        = 1'b1;
`endif

  assign rvalid  = !ar_empty && lat_ok;
  assign r_end   = (rbeat == ar_len_h);
  assign ar_pop  = rvalid && rready && r_end;
  assign rd_addr = (ar_addr_h & ~AXI_ADDR_W'(BYTES - 1)) + (AXI_ADDR_W'(rbeat) << ALIGN_W);
  assign rid     = rvalid ? ar_id_h : '0;
  assign rdata   = rvalid ? AXI_DATA_W'(rd_addr) : '0;
  assign rresp   = (rvalid && ar_err_h) ? RESP_SLVERR : RESP_OKAY;
  assign rlast   = rvalid && r_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                rbeat <= '0;
    else if (rvalid && rready)   rbeat <= r_end ? '0 : rbeat + BEAT_W'(1);
  end
endmodule

// File: tb/tb_axi_slv_model.sv
// Bench for axi_slv_model: directed checks on a BP_MODE=0 instance and a
// randomized scoreboard run on a BP_MODE=1 instance.
module tb_axi_slv_model;
`ifdef AXI_SLV_MODEL_RDLAT_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic awvalid[2], awready[2], wvalid[2], wready[2], wlast[2], bvalid[2], bready[2];
  logic arvalid[2], arready[2], rvalid[2], rready[2], rlast[2], proto_err[2];
  logic [3:0]  awid[2], awlen[2], bid[2], arid[2], arlen[2], rid[2];
  logic [31:0] awaddr[2], araddr[2], rdata[2];
  logic [1:0]  bresp[2], rresp[2];
  int total = 0, passed = 0;

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_slv_model #(.BP_MODE(g)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid[g]), .awready(awready[g]), .awid(awid[g]), .awaddr(awaddr[g]), .awlen(awlen[g]),
      .wvalid(wvalid[g]), .wready(wready[g]), .wlast(wlast[g]),
      .bvalid(bvalid[g]), .bready(bready[g]), .bid(bid[g]), .bresp(bresp[g]),
      .arvalid(arvalid[g]), .arready(arready[g]), .arid(arid[g]), .araddr(araddr[g]), .arlen(arlen[g]),
      .rvalid(rvalid[g]), .rready(rready[g]), .rid(rid[g]), .rdata(rdata[g]), .rresp(rresp[g]),
      .rlast(rlast[g]), .proto_err(proto_err[g])
    );
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_zero(input string tag, input int d);
    chk(tag, {awready[d], wready[d], bvalid[d], arready[d], rvalid[d], rlast[d], proto_err[d],
              bid[d], bresp[d], rid[d], rdata[d], rresp[d]}, 64'd0);
  endtask

  // All drive tasks start and end one time unit after a rising edge
  task automatic aw_send(input int d, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n = 0;
    awvalid[d] = 1'b1; awid[d] = id; awaddr[d] = addr; awlen[d] = len;
    @(negedge aclk);
    while (!awready[d] && n < 100) begin step(); @(negedge aclk); n++; end
    chk("aw_handshake", awready[d], 1);
    step();
    awvalid[d] = 1'b0;
  endtask

  task automatic ar_send(input int d, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n = 0;
    arvalid[d] = 1'b1; arid[d] = id; araddr[d] = addr; arlen[d] = len;
    @(negedge aclk);
    while (!arready[d] && n < 100) begin step(); @(negedge aclk); n++; end
    chk("ar_handshake", arready[d], 1);
    step();
    arvalid[d] = 1'b0;
  endtask

  task automatic w_send(input int d, input int beats, input logic [15:0] lmask, input bit gaps);
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      wvalid[d] = 1'b1; wlast[d] = lmask[i];
      @(negedge aclk);
      while (!wready[d] && n < 100) begin step(); @(negedge aclk); n++; end
      chk("w_handshake", wready[d], 1);
      step();
      wvalid[d] = 1'b0; wlast[d] = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic b_collect(input int d, input logic [3:0] id, input logic [1:0] resp, input bit rnd);
    bit got = 0, held = 0;
    logic [5:0] snap = '0;
    int n = 0;
    while (!got && n < 300) begin
      bready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (held) chk("b_stable", {bvalid[d], bid[d], bresp[d]}, {1'b1, snap});
      held = 0;
      if (bvalid[d] && bready[d]) begin
        chk("bid", bid[d], id);
        chk("bresp", bresp[d], resp);
        got = 1;
      end else if (bvalid[d]) begin
        held = 1;
        snap = {bid[d], bresp[d]};
      end
      step();
      n++;
    end
    chk("b_seen", got, 1);
    bready[d] = 1'b0;
  endtask

  // Reference: beat k returns the bus-aligned address plus k*4 bytes
  task automatic r_collect(input int d, input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input bit err, input bit rnd);
    logic [31:0] base;
    base = addr & ~32'h3;
    for (int b = 0; b <= int'(len); b++) begin
      bit got = 0, held = 0;
      logic [38:0] snap = '0;
      int n = 0;
      while (!got && n < 300) begin
        rready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge aclk);
        if (held) chk("r_stable", {rvalid[d], rid[d], rdata[d], rresp[d], rlast[d]}, {1'b1, snap});
        held = 0;
        if (rvalid[d] && rready[d]) begin
          chk("rid", rid[d], id);
          chk("rdata", rdata[d], base + 32'(b * 4));
          chk("rresp", rresp[d], err ? 2'b10 : 2'b00);
          chk("rlast", rlast[d], b == int'(len));
          got = 1;
        end else if (rvalid[d]) begin
          held = 1;
          snap = {rid[d], rdata[d], rresp[d], rlast[d]};
        end
        step();
        n++;
      end
      chk("r_seen", got, 1);
    end
    rready[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; awid[d] = 0; awaddr[d] = 0; awlen[d] = 0;
      wvalid[d] = 0; wlast[d] = 0; bready[d] = 0;
      arvalid[d] = 0; arid[d] = 0; araddr[d] = 0; arlen[d] = 0; rready[d] = 0;
    end
    #12;
    chk_zero("reset_outs0", 0);
    chk_zero("reset_outs1", 1);
    @(negedge aclk);
    aresetn = 1'b1;
    #2;
    chk("ready_before_edge", awready[0], 0);
    step();
    chk("awready_after_edge", awready[0], 1);
    chk("arready_after_edge", arready[0], 1);
    chk("w_held_without_aw", wready[0], 0);

    // Basic write burst, B timing
    aw_send(0, 4'd3, 32'h100, 4'd3);
    @(negedge aclk);
    chk("no_b_before_w", bvalid[0], 0);
    step();
    w_send(0, 4, 16'h0008, 0);
    chk("b_next_cycle", bvalid[0], 1);
    chk("bid_early", bid[0], 3);
    b_collect(0, 4'd3, 2'b00, 0);
    @(negedge aclk);
    chk("single_b", bvalid[0], 0);
    chk("proto_err_clean", proto_err[0], 0);
    step();

    // Basic read burst, first-beat latency
    ar_send(0, 4'd5, 32'h204, 4'd2);
    for (int k = 0; k <= EXP_LAT; k++) begin
      @(negedge aclk);
      chk("r_first_latency", rvalid[0], k == EXP_LAT);
      step();
    end
    r_collect(0, 4'd5, 32'h204, 4'd2, 0, 0);

    // Error window
    ar_send(0, 4'd1, 32'hF000_0010, 4'd0);
    r_collect(0, 4'd1, 32'hF000_0010, 4'd0, 1, 0);
    aw_send(0, 4'd2, 32'hF000_0000, 4'd0);
    w_send(0, 1, 16'h0001, 0);
    b_collect(0, 4'd2, 2'b10, 0);

    // AR FIFO fills at OSTD_DEPTH, then drains in order
    for (int i = 0; i < 4; i++) ar_send(0, 4'(i), 32'(i * 64), 4'd1);
    repeat (3) begin
      @(negedge aclk);
      chk("ar_full_stall", arready[0], 0);
      step();
    end
    fork
      begin
        ar_send(0, 4'd4, 32'd256, 4'd1);
        ar_send(0, 4'd5, 32'd320, 4'd1);
      end
      begin
        for (int i = 0; i < 6; i++) r_collect(0, 4'(i), 32'(i * 64), 4'd1, 0, 0);
      end
    join
    @(negedge aclk);
    chk("r_drained", rvalid[0], 0);
    step();

    // Early wlast: sticky error, B still follows the count
    aw_send(0, 4'd6, 32'h300, 4'd3);
    w_send(0, 4, 16'h000A, 0);
    chk("proto_err_set", proto_err[0], 1);
    b_collect(0, 4'd6, 2'b00, 0);
    aw_send(0, 4'd7, 32'h0, 4'd0);
    w_send(0, 1, 16'h0001, 0);
    b_collect(0, 4'd7, 2'b00, 0);
    chk("proto_err_sticky", proto_err[0], 1);

    // Randomized bursts under LFSR back-pressure
    for (int t = 0; t < 200; t++) begin
      logic [3:0]  id, len;
      logic [31:0] addr;
      bit          err;
      id = 4'($urandom);
      len = 4'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) == 0) addr[31:28] = 4'hF;
      err = ((addr & 32'hF000_0000) == 32'hF000_0000);
      if ($urandom_range(0, 1) == 1) begin
        ar_send(1, id, addr, len);
        r_collect(1, id, addr, len, err, 1);
      end else begin
        aw_send(1, id, addr, len);
        w_send(1, int'(len) + 1, 16'd1 << len, 1);
        b_collect(1, id, err ? 2'b10 : 2'b00, 1);
      end
    end
    chk("proto_err_random", proto_err[1], 0);

    // Reset in the middle of a read burst and a write burst
    ar_send(1, 4'd4, 32'h80, 4'd15);
    aw_send(1, 4'd9, 32'h40, 4'd3);
    w_send(1, 2, 16'h0000, 0);
    rready[1] = 1'b1;
    repeat (6) step();
    aresetn = 1'b0;
    rready[1] = 1'b0;
    #1;
    chk_zero("midburst_reset_outs", 1);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) step();
    chk("no_r_after_reset", rvalid[1], 0);
    chk("no_b_after_reset", bvalid[1], 0);
    aw_send(1, 4'd10, 32'h0, 4'd1);
    w_send(1, 2, 16'h0002, 0);
    b_collect(1, 4'd10, 2'b00, 0);
    chk("proto_err_after_reset", proto_err[1], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
